// File: rtl/microwave_pkg.sv
// Shared encodings and digit widths for the microwave cook-time controller.
package microwave_pkg;

  localparam int unsigned DIGIT_W          = 4;
  localparam int unsigned STATE_W          = 2;
  localparam int unsigned BEEP_CNT_W       = 4;
  localparam int unsigned BCD_MAX_ONES     = 9;
  localparam int unsigned BCD_MAX_SEC_TENS = 5;

  localparam logic [STATE_W-1:0] ST_IDLE    = 2'd0;
  localparam logic [STATE_W-1:0] ST_COOKING = 2'd1;
  localparam logic [STATE_W-1:0] ST_PAUSED  = 2'd2;
  localparam logic [STATE_W-1:0] ST_DONE    = 2'd3;

  typedef struct packed {
    logic [DIGIT_W-1:0] min_tens;
    logic [DIGIT_W-1:0] min_ones;
    logic [DIGIT_W-1:0] sec_tens;
    logic [DIGIT_W-1:0] sec_ones;
  } bcd_time_t;

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit of the mm:ss countdown: clear, shift-load, or decrement with wrap.
module bcd_digit_down
  import microwave_pkg::*;
#(
  parameter int unsigned WRAP = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               load_en,
  input  logic [DIGIT_W-1:0] load_val,
  input  logic               dec_en,
  output logic [DIGIT_W-1:0] digit,
  output logic               borrow_out
);

  logic [DIGIT_W-1:0] digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (clear) begin
      digit_d = '0;
    end else if (load_en) begin
      digit_d = load_val;
    end else if (dec_en) begin
      digit_d = (digit_q == '0) ? DIGIT_W'(WRAP) : digit_q - DIGIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) digit_q <= '0;
    else        digit_q <= digit_d;
  end

  assign digit      = digit_q;
  assign borrow_out = dec_en & (digit_q == '0);

endmodule

// File: rtl/microwave_timer_ctrl.sv
// Microwave cook-time controller: keypad setpoint entry, 1 Hz countdown,
// IDLE/COOKING/PAUSED/DONE sequencing, magnetron gate and end-of-cook beeper.
module microwave_timer_ctrl
  import microwave_pkg::*;
#(
  parameter int unsigned BEEP_TICKS = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_digit,
  input  logic               start,
  input  logic               stop_clear,
  input  logic               door_closed,
  output logic [DIGIT_W-1:0] min_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic [STATE_W-1:0] state,
  output logic               magnetron_on,
  output logic               beep
);

  logic [STATE_W-1:0]    state_q, state_d;
  logic [BEEP_CNT_W-1:0] beep_cnt_q, beep_cnt_d;
  logic                  mag_q, beep_q;
  logic                  clear_c, load_c, dec_c;
  logic                  borrow_so, borrow_st, borrow_mo, borrow_mt;
  logic                  key_ok, digits_zero, digits_one;
  bcd_time_t             time_c;

  assign time_c      = {min_tens, min_ones, sec_tens, sec_ones};
  assign digits_zero = (time_c == 16'h0000);
  assign digits_one  = (time_c == 16'h0001);
  assign key_ok      = key_valid && (key_digit <= 4'd9);

  // Next-state decode; branch order inside each state encodes input priority.
  always_comb begin
    state_d    = state_q;
    beep_cnt_d = beep_cnt_q;
    clear_c    = 1'b0;
    load_c     = 1'b0;
    dec_c      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (stop_clear) begin
          clear_c = 1'b1;
        end else if (start) begin
          if (door_closed && !digits_zero) state_d = ST_COOKING;
        end else if (key_ok) begin
          load_c = 1'b1;
        end
      end
      ST_COOKING: begin
        if (stop_clear || !door_closed) begin
          state_d = ST_PAUSED;
        end else if (tick) begin
          dec_c = 1'b1;
          // A borrow out of min_tens would mean underflow; treat it as finished.
          if (digits_one || borrow_mt) state_d = ST_DONE;
        end
      end
      ST_PAUSED: begin
        if (stop_clear) begin
          state_d = ST_IDLE;
          clear_c = 1'b1;
        end else if (start && door_closed) begin
          state_d = ST_COOKING;
        end
      end
      ST_DONE: begin
        if (stop_clear || !door_closed) begin
          state_d    = ST_IDLE;
          beep_cnt_d = '0;
        end else if (tick) begin
          if (beep_cnt_q == BEEP_CNT_W'(BEEP_TICKS - 1)) begin
            state_d    = ST_IDLE;
            beep_cnt_d = '0;
          end else begin
            beep_cnt_d = beep_cnt_q + BEEP_CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      beep_cnt_q <= '0;
      mag_q      <= 1'b0;
      beep_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      beep_cnt_q <= beep_cnt_d;
      mag_q      <= (state_d == ST_COOKING);
      beep_q     <= (state_d == ST_DONE);
    end
  end

  assign state        = state_q;
  assign magnetron_on = mag_q;
  assign beep         = beep_q;

  // Digit chain, least significant first; entry shifts each digit one place left.
  bcd_digit_down #(.WRAP(BCD_MAX_ONES)) u_sec_ones (
    .clk(clk), .reset(reset), .clear(clear_c), .load_en(load_c),
    .load_val(key_digit), .dec_en(dec_c),
    .digit(sec_ones), .borrow_out(borrow_so)
  );

  bcd_digit_down #(.WRAP(BCD_MAX_SEC_TENS)) u_sec_tens (
    .clk(clk), .reset(reset), .clear(clear_c), .load_en(load_c),
    .load_val(sec_ones), .dec_en(borrow_so),
    .digit(sec_tens), .borrow_out(borrow_st)
  );

  bcd_digit_down #(.WRAP(BCD_MAX_ONES)) u_min_ones (
    .clk(clk), .reset(reset), .clear(clear_c), .load_en(load_c),
    .load_val(sec_tens), .dec_en(borrow_st),
    .digit(min_ones), .borrow_out(borrow_mo)
  );

  bcd_digit_down #(.WRAP(BCD_MAX_ONES)) u_min_tens (
    .clk(clk), .reset(reset), .clear(clear_c), .load_en(load_c),
    .load_val(min_ones), .dec_en(borrow_mo),
    .digit(min_tens), .borrow_out(borrow_mt)
  );

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Directed bench for microwave_timer_ctrl with a decimal-arithmetic reference model.
module tb_microwave_timer_ctrl;

  localparam int unsigned BT = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       start = 1'b0;
  logic       stop_clear = 1'b0;
  logic       door_closed = 1'b1;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic [1:0] state;
  logic       magnetron_on, beep;

  microwave_timer_ctrl #(.BEEP_TICKS(BT)) dut (
    .clk(clk), .reset(reset), .tick(tick), .key_valid(key_valid),
    .key_digit(key_digit), .start(start), .stop_clear(stop_clear),
    .door_closed(door_closed), .min_tens(min_tens), .min_ones(min_ones),
    .sec_tens(sec_tens), .sec_ones(sec_ones), .state(state),
    .magnetron_on(magnetron_on), .beep(beep)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Reference: setpoint as a decimal integer mmss, plus remaining beep ticks.
  int m_state = 0;
  int m_val = 0;
  int m_beep_left = 0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int to_bcd(input int v);
    return ((v / 1000) << 12) | (((v / 100) % 10) << 8) | (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  function automatic int dec_time(input int v);
    if (v % 100 > 0) return v - 1;
    return v - 100 + 59;
  endfunction

  function automatic int dig();
    return int'({min_tens, min_ones, sec_tens, sec_ones});
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_state = 0; m_val = 0; m_beep_left = 0;
    end else begin
      case (m_state)
        0: begin
          if (stop_clear) m_val = 0;
          else if (start) begin
            if (door_closed && m_val != 0) m_state = 1;
          end else if (key_valid && key_digit <= 9) m_val = (m_val * 10 + int'(key_digit)) % 10000;
        end
        1: begin
          if (stop_clear || !door_closed) m_state = 2;
          else if (tick) begin
            if (m_val == 1) begin m_state = 3; m_beep_left = BT; end
            m_val = dec_time(m_val);
          end
        end
        2: begin
          if (stop_clear) begin m_state = 0; m_val = 0; end
          else if (start && door_closed) m_state = 1;
        end
        default: begin
          if (stop_clear || !door_closed) m_state = 0;
          else if (tick) begin
            m_beep_left--;
            if (m_beep_left == 0) m_state = 0;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_digits", dig(), to_bcd(m_val));
      check("model_state", int'(state), m_state);
      check("model_magnetron", int'(magnetron_on), (m_state == 1) ? 1 : 0);
      check("model_beep", int'(beep), (m_state == 3) ? 1 : 0);
    end
  end

  task automatic step(input bit t, input bit kv, input logic [3:0] kd, input bit s, input bit sc);
    tick = t; key_valid = kv; key_digit = kd; start = s; stop_clear = sc;
    @(negedge clk);
    tick = 1'b0; key_valid = 1'b0; start = 1'b0; stop_clear = 1'b0;
  endtask

  task automatic idle();             step(0, 0, 4'd0, 0, 0); endtask
  task automatic key(input int d);   step(0, 1, 4'(d), 0, 0); endtask
  task automatic go();               step(0, 0, 4'd0, 1, 0); endtask
  task automatic clr();              step(0, 0, 4'd0, 0, 1); endtask
  task automatic tk(input int n);    for (int i = 0; i < n; i++) step(1, 0, 4'd0, 0, 0); endtask
  task automatic to_idle();          clr(); clr(); endtask

  initial begin
    cmp_en = 1'b1;
    reset = 1'b0;
    idle();
    reset = 1'b1;
    check("rst_digits", dig(), 'h0000);
    check("rst_state", int'(state), 0);
    check("rst_mag", int'(magnetron_on), 0);
    check("rst_beep", int'(beep), 0);

    key(1); key(3); key(0);
    check("entry_0130", dig(), 'h0130);
    check("entry_state", int'(state), 0);
    key(12);
    check("key_gt9_ignored", dig(), 'h0130);

    go();
    check("start_state", int'(state), 1);
    check("start_mag", int'(magnetron_on), 1);
    tk(1);
    check("tick_0129", dig(), 'h0129);

    to_idle(); key(1); key(0); key(0); go(); tk(1);
    check("borrow_0059", dig(), 'h0059);
    to_idle(); key(1); key(0); key(0); key(0); go(); tk(1);
    check("borrow_0959", dig(), 'h0959);
    to_idle(); key(9); key(0); go(); tk(1);
    check("sectens9_0089", dig(), 'h0089);
    to_idle(); key(1); key(2); key(3); key(4); key(5);
    check("fifth_digit_drop", dig(), 'h2345);

    to_idle(); key(4); key(5);
    step(1, 0, 4'd0, 1, 0);
    check("start_tick_ignored", dig(), 'h0045);
    check("start_tick_state", int'(state), 1);
    door_closed = 1'b0;
    step(1, 0, 4'd0, 0, 0);
    check("door_pause_state", int'(state), 2);
    check("door_pause_hold", dig(), 'h0045);
    check("door_pause_mag", int'(magnetron_on), 0);
    tk(2);
    check("paused_frozen", dig(), 'h0045);
    door_closed = 1'b1;
    go();
    check("resume_state", int'(state), 1);
    tk(1);
    check("resume_0044", dig(), 'h0044);

    to_idle(); key(2); go(); tk(2);
    check("done_digits", dig(), 'h0000);
    check("done_state", int'(state), 3);
    check("done_beep", int'(beep), 1);
    check("done_mag", int'(magnetron_on), 0);
    tk(2);
    check("done_still_beeping", int'(state), 3);
    tk(1);
    check("beep_end_state", int'(state), 0);
    check("beep_end_beep", int'(beep), 0);
    idle();
    key(2); go(); tk(2); clr();
    check("done_clear_state", int'(state), 0);
    check("done_clear_beep", int'(beep), 0);
    key(2); go(); tk(2);
    door_closed = 1'b0;
    idle();
    check("done_door_state", int'(state), 0);
    door_closed = 1'b1;

    door_closed = 1'b0;
    key(5); go();
    check("start_door_open", int'(state), 0);
    door_closed = 1'b1;
    clr(); go();
    check("start_zero", int'(state), 0);
    check("start_zero_mag", int'(magnetron_on), 0);

    key(5); key(1); key(7); go();
    check("cook_0517", dig(), 'h0517);
    reset = 1'b0;
    idle();
    reset = 1'b1;
    check("rst_cook_digits", dig(), 'h0000);
    check("rst_cook_state", int'(state), 0);
    check("rst_cook_mag", int'(magnetron_on), 0);
    key(3);
    reset = 1'b0;
    go();
    reset = 1'b1;
    check("rst_vs_start_state", int'(state), 0);
    check("rst_vs_start_digits", dig(), 'h0000);
    idle(); idle();

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/microwave_timer_ctrl.md
Name: microwave_timer_ctrl

Overview:
Cook-time controller for the microwave. Holds a 4-digit BCD mm:ss setpoint entered from the keypad and counts it down once per 1 Hz tick using cascaded mod-10/mod-6 digit down-counters. Runs the IDLE/COOKING/PAUSED/DONE state machine, gates the magnetron and drives the end-of-cook beeper. Sits between the keypad decoder/second prescaler and the 7-segment display and power-stage drivers.

Parameters:
BEEP_TICKS, 3, number of tick pulses the beep output stays high in DONE (1..15)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
tick  in  1  one-cycle pulse per second from prescaler
key_valid  in  1  one-cycle strobe, key_digit valid
key_digit  in  4  BCD digit from keypad; values >9 ignored
start  in  1  one-cycle start/resume strobe
stop_clear  in  1  one-cycle stop/clear strobe
door_closed  in  1  level, 1 = door closed
min_tens  out  4  BCD minutes tens
min_ones  out  4  BCD minutes ones
sec_tens  out  4  BCD seconds tens
sec_ones  out  4  BCD seconds ones
state  out  2  IDLE=0, COOKING=1, PAUSED=2, DONE=3
magnetron_on  out  1  1 iff state==COOKING
beep  out  1  end-of-cook beeper

Behaviour:
- Reset (reset==0 at clk edge): state=IDLE, all digits 0, magnetron_on=0, beep=0, beep counter 0. Reset wins over every other input, including mid-COOKING.
- All outputs registered; response to an input strobe appears one clock after the edge that samples it.
- Per-cycle input priority: stop_clear > door open > start > key_valid > tick.
- IDLE: key_valid with digit<=9 shifts left: {mt,mo,st,so} <= {mo,st,so,key_digit}; fifth digit drops mt. start with door_closed=1 and digits!=0000 -> COOKING. start with door open or digits==0000 -> ignored. stop_clear -> digits cleared. tick ignored.
- COOKING: each tick decrements mm:ss. sec_ones 9..0 wraps to 9 with borrow. sec_tens wraps 0 -> 5 on borrow. min_ones wraps to 9 with borrow. min_tens decrements on borrow. Entered sec_tens 6..9 are legal and count down normally (e.g. 0:90 -> 0:89).
- COOKING exits: tick when value is 00:01 -> digits 00:00, state DONE in the same edge. door_closed==0 -> PAUSED, with no decrement even if tick is coincident. stop_clear -> PAUSED, digits held. key_valid and start are ignored.
- Countdown starts on the first tick after entering COOKING. A tick coincident with the start strobe is ignored.
- PAUSED: digits frozen. start with door_closed=1 -> COOKING. stop_clear -> IDLE with digits cleared. key_valid and tick ignored.
- DONE: beep=1 and magnetron_on=0. Count BEEP_TICKS ticks, then go to IDLE with beep=0. stop_clear or door open -> IDLE immediately with beep=0. Digits stay 00:00.
- magnetron_on is registered from the next-state decode, so it is never high outside COOKING.

Decomposition:
- Package microwave_pkg: state encoding localparams (ST_IDLE..ST_DONE), BCD_MAX_ONES=9, BCD_MAX_SEC_TENS=5, 4-bit BCD digit width.
- One sub-module bcd_digit_down.
  - Parameter WRAP (9 or 5).
  - Inputs: clk, reset, clear, load_en/load_val, dec_en.
  - Outputs: digit[3:0], borrow_out (combinational, = dec_en & digit==0).
  - Four instances, chained through borrow_out.
  - The shift-entry path uses load_en.

Test Plan:
1. Reset low 1 cycle. Keys 1, 3, 0 -> digits 01:30, state 0. Key 12 -> no change.
2. From 01:30: start, then 1 tick -> 01:29, magnetron_on=1. From 01:00: 1 tick -> 00:59. From 10:00: 1 tick -> 09:59.
3. COOKING at 00:45: drop door_closed with a coincident tick -> PAUSED, 00:45 held, magnetron_on=0. Close door, start -> COOKING. Next tick -> 00:44.
4. Start from 00:02 with BEEP_TICKS=3: 2 ticks -> 00:00, DONE, beep=1. 3 more ticks -> IDLE, beep=0. Repeat with stop_clear on the 1st DONE cycle -> IDLE next clock.
5. Start with door open, or with 00:00 -> state stays IDLE, magnetron_on never 1.
6. Reset held low during COOKING at 05:17 -> next clock IDLE, 00:00, magnetron_on=0, beep=0. Reset with a coincident start -> reset wins.
